// File: rtl/mnist_bnn_classifier.sv
// Binary template-matching classifier for 14x14 binarized MNIST images.
// One template row is compared per cycle; ten classes take 140 cycles in total.
module mnist_bnn_classifier #(
    parameter logic [1959:0] WEIGHTS = '0
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [195:0] image_data,
    input  logic         image_ready,
    output logic [3:0]   digit,
    output logic [7:0]   score,
    output logic         digit_valid,
    output logic         busy
);

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    function automatic logic [3:0] popcount14(input logic [13:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 14; i++) begin
            n = n + {3'd0, v[i]};
        end
        return n;
    endfunction

    state_t       state_q, state_d;
    logic         image_ready_q, image_ready_d;
    logic [195:0] img_q, img_d;
    logic [3:0]   cls_q, cls_d;
    logic [3:0]   row_q, row_d;
    logic [7:0]   acc_q, acc_d;
    logic [7:0]   best_score_q, best_score_d;
    logic [3:0]   best_class_q, best_class_d;
    logic [3:0]   digit_q, digit_d;
    logic [7:0]   score_q, score_d;
    logic         valid_q, valid_d;

    logic         start;
    logic [7:0]   img_idx;
    logic [10:0]  w_idx;
    logic [13:0]  img_row;
    logic [13:0]  w_row;
    logic [3:0]   match_cnt;
    logic [7:0]   total;
    logic [7:0]   win_score;
    logic [3:0]   win_class;

    // Row r of the image and of class c's template sit at fixed MSB-first offsets.
    always_comb begin
        start     = image_ready & ~image_ready_q;
        img_idx   = 8'd195 - 8'd14 * {4'd0, row_q};
        w_idx     = 11'd1959 - 11'd196 * {7'd0, cls_q} - 11'd14 * {7'd0, row_q};
        img_row   = img_q[img_idx -: 14];
        w_row     = WEIGHTS[w_idx -: 14];
        match_cnt = popcount14(~(img_row ^ w_row));
        total     = acc_q + {4'd0, match_cnt};
    end

    always_comb begin
        state_d       = state_q;
        image_ready_d = image_ready;
        img_d         = img_q;
        cls_d         = cls_q;
        row_d         = row_q;
        acc_d         = acc_q;
        best_score_d  = best_score_q;
        best_class_d  = best_class_q;
        digit_d       = digit_q;
        score_d       = score_q;
        valid_d       = valid_q;
        win_score     = best_score_q;
        win_class     = best_class_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    img_d        = image_data;
                    cls_d        = '0;
                    row_d        = '0;
                    acc_d        = '0;
                    best_score_d = '0;
                    best_class_d = '0;
                    valid_d      = 1'b0;
                    state_d      = ACCUM;
                end
            end
            ACCUM: begin
                if (row_q == 4'd13) begin
                    // Strict compare so a tie keeps the lower class index.
                    if (cls_q == 4'd0 || total > best_score_q) begin
                        win_score = total;
                        win_class = cls_q;
                    end
                    best_score_d = win_score;
                    best_class_d = win_class;
                    acc_d        = '0;
                    row_d        = '0;
                    if (cls_q == 4'd9) begin
                        digit_d = win_class;
                        score_d = win_score;
                        valid_d = 1'b1;
                        state_d = DONE;
                    end else begin
                        cls_d = cls_q + 4'd1;
                    end
                end else begin
                    acc_d = total;
                    row_d = row_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            image_ready_q <= 1'b0;
            img_q         <= '0;
            cls_q         <= '0;
            row_q         <= '0;
            acc_q         <= '0;
            best_score_q  <= '0;
            best_class_q  <= '0;
            digit_q       <= '0;
            score_q       <= '0;
            valid_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            image_ready_q <= image_ready_d;
            img_q         <= img_d;
            cls_q         <= cls_d;
            row_q         <= row_d;
            acc_q         <= acc_d;
            best_score_q  <= best_score_d;
            best_class_q  <= best_class_d;
            digit_q       <= digit_d;
            score_q       <= score_d;
            valid_q       <= valid_d;
        end
    end

    assign digit       = digit_q;
    assign score       = score_q;
    assign digit_valid = valid_q;
    assign busy        = (state_q == ACCUM);

endmodule

// File: tb/tb_mnist_bnn_classifier.sv
// Randomized bench for mnist_bnn_classifier: four instances with different template
// sets share one stimulus stream and are compared against a whole-image matching model.
module tb_mnist_bnn_classifier;

    localparam logic [195:0] P = {4'hB, 64'h0123_4567_89AB_CDEF,
                                  64'hF0E1_D2C3_B4A5_9687, 64'h5A5A_3C3C_0FF0_9669};

    function automatic logic [1959:0] mk_w(input logic [31:0] seed);
        logic [31:0]   s;
        logic [1959:0] w;
        s = seed;
        w = '0;
        for (int i = 0; i < 62; i++) begin
            s = s ^ (s << 13);
            s = s ^ (s >> 17);
            s = s ^ (s << 5);
            w = {w[1927:0], s};
        end
        return w;
    endfunction

    localparam logic [1959:0] WA = {~P, ~P, ~P, P, ~P, ~P, ~P, ~P, ~P, ~P};
    localparam logic [1959:0] WB = {10{P}};
    localparam logic [1959:0] WC = '0;
    localparam logic [1959:0] WD = mk_w(32'h2468ACE1);

    logic         clk;
    logic         reset_n;
    logic [195:0] image_data;
    logic         image_ready;
    logic [3:0]   dg_a, dg_b, dg_c, dg_d;
    logic [7:0]   sc_a, sc_b, sc_c, sc_d;
    logic         vl_a, vl_b, vl_c, vl_d;
    logic         busy_a, busy_b, busy_c, busy_d;

    int errs;
    int checks;

    mnist_bnn_classifier #(.WEIGHTS(WA)) u_a (.clk(clk), .reset_n(reset_n), .image_data(image_data),
        .image_ready(image_ready), .digit(dg_a), .score(sc_a), .digit_valid(vl_a), .busy(busy_a));
    mnist_bnn_classifier #(.WEIGHTS(WB)) u_b (.clk(clk), .reset_n(reset_n), .image_data(image_data),
        .image_ready(image_ready), .digit(dg_b), .score(sc_b), .digit_valid(vl_b), .busy(busy_b));
    mnist_bnn_classifier #(.WEIGHTS(WC)) u_c (.clk(clk), .reset_n(reset_n), .image_data(image_data),
        .image_ready(image_ready), .digit(dg_c), .score(sc_c), .digit_valid(vl_c), .busy(busy_c));
    mnist_bnn_classifier #(.WEIGHTS(WD)) u_d (.clk(clk), .reset_n(reset_n), .image_data(image_data),
        .image_ready(image_ready), .digit(dg_d), .score(sc_d), .digit_valid(vl_d), .busy(busy_d));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Each class score is the count of agreeing pixels over the whole image.
    function automatic void model(input logic [1959:0] w, input logic [195:0] img,
                                  output int d, output int s);
        int t;
        s = -1;
        d = 0;
        for (int c = 0; c < 10; c++) begin
            t = $countones(~(img ^ w[1959 - 196 * c -: 196]));
            if (t > s) begin
                s = t;
                d = c;
            end
        end
    endfunction

    function automatic logic [195:0] rand_img();
        logic [223:0] t;
        t = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        return t[195:0];
    endfunction

    task automatic check_inst(input string tag, input logic [1959:0] w, input logic [195:0] img,
                              input logic [3:0] dg, input logic [7:0] sc, input logic vl);
        int d, s;
        model(w, img, d, s);
        chk({tag, "_digit"}, 32'(dg), 32'(d));
        chk({tag, "_score"}, 32'(sc), 32'(s));
        chk({tag, "_valid"}, 32'(vl), 32'd1);
    endtask

    task automatic check_all(input string tag, input logic [195:0] img);
        check_inst({tag, "_a"}, WA, img, dg_a, sc_a, vl_a);
        check_inst({tag, "_b"}, WB, img, dg_b, sc_b, vl_b);
        check_inst({tag, "_c"}, WC, img, dg_c, sc_c, vl_c);
        check_inst({tag, "_d"}, WD, img, dg_d, sc_d, vl_d);
    endtask

    // mode 0: single pulse; 1: image toggles every cycle; 2: ready held high;
    // 3: second rising edge on ready in the middle of the computation.
    task automatic run(input string tag, input logic [195:0] img, input int mode);
        int busy_cnt;
        int early;
        busy_cnt    = 0;
        early       = 0;
        image_data  = img;
        image_ready = 1'b1;
        for (int i = 0; i <= 140; i++) begin
            @(posedge clk);
            #1;
            if (busy_a) busy_cnt++;
            if (i < 140 && vl_a) early++;
            if (mode != 2 && i == 0) image_ready = 1'b0;
            if (mode == 1) image_data = rand_img();
            if (mode == 3 && i == 50) image_ready = 1'b1;
            if (mode == 3 && i == 51) image_ready = 1'b0;
        end
        chk({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd140);
        chk({tag, "_early_valid"}, 32'(early), 32'd0);
        chk({tag, "_busy_after"}, 32'(busy_a), 32'd0);
        check_all(tag, img);
    endtask

    initial begin
        logic [195:0] img;
        logic [3:0]   held_digit;
        int           bad_valid;
        int           bad_busy;
        int           bad_digit;

        clk         = 1'b0;
        reset_n     = 1'b0;
        image_ready = 1'b0;
        image_data  = '0;
        errs        = 0;
        checks      = 0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_digit", 32'(dg_a), 32'd0);
        chk("rst_score", 32'(sc_d), 32'd0);
        chk("rst_valid", 32'(vl_a | vl_d), 32'd0);
        chk("rst_busy", 32'(busy_a | busy_d), 32'd0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("idle_busy", 32'(busy_a), 32'd0);

        run("pat", P, 0);
        chk("pat_class3_digit", 32'(dg_a), 32'd3);
        chk("pat_class3_score", 32'(sc_a), 32'd196);
        chk("pat_tie_digit", 32'(dg_b), 32'd0);
        chk("pat_tie_score", 32'(sc_b), 32'd196);

        img = (196'd1 << 50) - 196'd1;
        run("ones50", img, 0);
        chk("ones50_zero_w_digit", 32'(dg_c), 32'd0);
        chk("ones50_zero_w_score", 32'(sc_c), 32'd146);

        for (int k = 0; k < 6; k++) begin
            run((k % 2 == 1) ? "rnd_toggle" : "rnd", rand_img(), k % 2);
        end

        run("no_restart", rand_img(), 3);

        img = rand_img();
        run("hold", img, 2);
        held_digit = dg_d;
        bad_valid  = 0;
        bad_busy   = 0;
        bad_digit  = 0;
        repeat (500) begin
            @(posedge clk);
            #1;
            if (!vl_a || !vl_d) bad_valid++;
            if (busy_a || busy_d) bad_busy++;
            if (dg_d !== held_digit) bad_digit++;
        end
        chk("hold_valid_drop", 32'(bad_valid), 32'd0);
        chk("hold_restarted", 32'(bad_busy), 32'd0);
        chk("hold_digit_moved", 32'(bad_digit), 32'd0);
        check_all("hold_end", img);
        image_ready = 1'b0;
        @(posedge clk);
        #1;

        image_data  = rand_img();
        image_ready = 1'b1;
        for (int i = 0; i < 70; i++) begin
            @(posedge clk);
            #1;
            if (i == 0) image_ready = 1'b0;
        end
        chk("midrst_busy_before", 32'(busy_a), 32'd1);
        chk("midrst_valid_before", 32'(vl_a), 32'd0);
        reset_n = 1'b0;
        #1;
        chk("midrst_digit", 32'(dg_a), 32'd0);
        chk("midrst_score", 32'(sc_a), 32'd0);
        chk("midrst_valid", 32'(vl_a), 32'd0);
        chk("midrst_busy", 32'(busy_a), 32'd0);
        chk("midrst_score_d", 32'(sc_d), 32'd0);
        @(posedge clk);
        #1;
        reset_n   = 1'b1;
        bad_valid = 0;
        bad_busy  = 0;
        repeat (150) begin
            @(posedge clk);
            #1;
            if (vl_a || vl_d) bad_valid++;
            if (busy_a || busy_d) bad_busy++;
        end
        chk("postrst_no_valid", 32'(bad_valid), 32'd0);
        chk("postrst_no_busy", 32'(bad_busy), 32'd0);
        run("postrst", rand_img(), 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
